// File: rtl/risc_v_mem_access_unit_if.sv
// Load/store request, response and data-memory bus bundle for the
// memory access unit; slave is the unit, master is the CPU/memory side.
interface risc_v_mem_access_unit_if;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;

    modport slave (
        input  start, is_store, funct3, addr, wdata, mem_dout,
        output busy, done, fault, rdata, mem_addr, mem_din, mem_we
    );

    modport master (
        output start, is_store, funct3, addr, wdata, mem_dout,
        input  busy, done, fault, rdata, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/risc_v_mem_access_unit.sv
// Load/store initiator for the multi-cycle RISC-V core: LB/LH/LW/LBU/LHU,
// SB/SH/SW with read-modify-write, rejects bad requests before memory.
module risc_v_mem_access_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input logic                      clk,
    input logic                      rst,
    risc_v_mem_access_unit_if.slave  mau_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RDWORD,
        S_WRITE,
        S_DONE,
        S_FAULT
    } state_e;

    state_e      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [15:0] wlow_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic        mem_we_q;

    logic        illegal_d;
    logic        misaligned_d;
    logic        range_d;
    logic        req_fault_d;
    logic [7:0]  lane_b_d;
    logic [15:0] lane_h_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    // Request screening on the live inputs, evaluated while IDLE
    always_comb begin
        illegal_d    = 1'b0;
        misaligned_d = 1'b0;
        if (mau_if.is_store) begin
            illegal_d = !(mau_if.funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal_d = mau_if.funct3 inside {3'b011, 3'b110, 3'b111};
        end
        unique case (mau_if.funct3[1:0])
            2'b01:   misaligned_d = mau_if.addr[0];
            2'b10:   misaligned_d = |mau_if.addr[1:0];
            default: misaligned_d = 1'b0;
        endcase
        range_d     = {2'b00, mau_if.addr[31:2]} >= 32'(MEM_WORDS);
        req_fault_d = illegal_d | misaligned_d | range_d;
    end

    always_comb begin
        lane_b_d = mau_if.mem_dout[{off_q, 3'b000} +: 8];
        lane_h_d = off_q[1] ? mau_if.mem_dout[31:16] : mau_if.mem_dout[15:0];
        unique case (funct3_q)
            3'b000:  load_d = {{24{lane_b_d[7]}}, lane_b_d};
            3'b001:  load_d = {{16{lane_h_d[15]}}, lane_h_d};
            3'b100:  load_d = {24'h0, lane_b_d};
            3'b101:  load_d = {16'h0, lane_h_d};
            default: load_d = mau_if.mem_dout;
        endcase
    end

    // Sub-word store: splice the new lane into the word just read back
    always_comb begin
        merge_d = mau_if.mem_dout;
        if (funct3_q[1:0] == 2'b00) begin
            merge_d[{off_q, 3'b000} +: 8] = wlow_q[7:0];
        end else if (off_q[1]) begin
            merge_d[31:16] = wlow_q;
        end else begin
            merge_d[15:0] = wlow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            wlow_q     <= 16'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= 32'h0;
            mem_addr_q <= 32'h0;
            mem_din_q  <= 32'h0;
            mem_we_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mau_if.start) begin
                        funct3_q <= mau_if.funct3;
                        off_q    <= mau_if.addr[1:0];
                        wlow_q   <= mau_if.wdata[15:0];
                        busy_q   <= 1'b1;
                        if (req_fault_d) begin
                            state_q <= S_FAULT;
                        end else begin
                            mem_addr_q <= {mau_if.addr[31:2], 2'b00};
                            if (!mau_if.is_store) begin
                                state_q <= S_LOAD;
                            end else if (mau_if.funct3[1:0] == 2'b10) begin
                                state_q   <= S_WRITE;
                                mem_we_q  <= 1'b1;
                                mem_din_q <= mau_if.wdata;
                            end else begin
                                state_q <= S_RDWORD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    rdata_q <= load_d;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_RDWORD: begin
                    mem_din_q <= merge_d;
                    mem_we_q  <= 1'b1;
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    mem_we_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    // First cycle arms the pulse, second cycle retires it
                    if (!done_q) begin
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        fault_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    fault_q  <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign mau_if.busy     = busy_q;
    assign mau_if.done     = done_q;
    assign mau_if.fault    = fault_q;
    assign mau_if.rdata    = rdata_q;
    assign mau_if.mem_addr = mem_addr_q;
    assign mau_if.mem_din  = mem_din_q;
    assign mau_if.mem_we   = mem_we_q;

endmodule

// File: tb/tb_risc_v_mem_access_unit.sv
// Directed bench for risc_v_mem_access_unit with a word memory model
// and an expected-result queue per request.
module tb_risc_v_mem_access_unit;

    localparam int MW = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc_v_mem_access_unit_if bus ();

    risc_v_mem_access_unit #(.MEM_WORDS(MW)) dut (
        .clk    (clk),
        .rst    (rst),
        .mau_if (bus)
    );

    logic [31:0] mem [MW];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_val;
    int          we_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_din;
    end

    always @(posedge clk) if (bus.mem_we) we_cnt <= we_cnt + 1;

    assign bus.mem_dout = mem[bus.mem_addr[11:2]];

    typedef struct {
        logic        fault;
        logic        is_load;
        logic [31:0] rdata;
        int          edges;
        int          wes;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic ef,
                          input logic [31:0] er, input int ee,
                          input int ewe);
        exp_t e;
        exp_t g;
        int   n;
        int   we0;
        e.fault   = ef;
        e.is_load = !st && !ef;
        e.rdata   = e.is_load ? er : last_rd;
        e.edges   = ee;
        e.wes     = ewe;
        sb.push_back(e);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.is_store = st;
        bus.funct3   = f3;
        bus.addr     = a;
        bus.wdata    = wd;
        we0          = we_cnt;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_busy0"}, bus.busy, 1);
        n = 1;
        @(negedge clk);
        while (!bus.done && n < 8) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        g = sb.pop_front();
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_lat"}, n, g.edges);
        chk({tag, "_fault"}, bus.fault, g.fault);
        chk({tag, "_rdata"}, bus.rdata, g.rdata);
        if (g.is_load) last_rd = g.rdata;
        @(negedge clk);
        chk({tag, "_pulse"}, bus.done, 0);
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_we"}, we_cnt - we0, g.wes);
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    initial begin
        exp_t g;
        rst          = 1'b1;
        pl_en        = 1'b0;
        pl_idx       = '0;
        pl_val       = '0;
        bus.start    = 1'b0;
        bus.is_store = 1'b0;
        bus.funct3   = 3'b000;
        bus.addr     = '0;
        bus.wdata    = '0;
        last_rd      = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_mdin", bus.mem_din, 0);
        chk("rst_mwe", bus.mem_we, 0);
        preload(10'd0, 32'h8899AABB);
        preload(10'd2, 32'h11111111);
        rst = 1'b0;

        do_req("lb3",  0, 3'b000, 32'd3, '0, 0, 32'hFFFFFF88, 2, 0);
        do_req("lbu3", 0, 3'b100, 32'd3, '0, 0, 32'h00000088, 2, 0);
        do_req("lh2",  0, 3'b001, 32'd2, '0, 0, 32'hFFFF8899, 2, 0);
        do_req("lhu0", 0, 3'b101, 32'd0, '0, 0, 32'h0000AABB, 2, 0);
        do_req("lw0",  0, 3'b010, 32'd0, '0, 0, 32'h8899AABB, 2, 0);
        do_req("sb1",  1, 3'b000, 32'd1, 32'h00000012, 0, '0, 3, 1);
        chk("sb1_mem", mem[0], 32'h889912BB);
        do_req("sh2",  1, 3'b001, 32'd2, 32'h00005566, 0, '0, 3, 1);
        do_req("sw4",  1, 3'b010, 32'd4, 32'hDEADBEEF, 0, '0, 2, 1);
        chk("sh2_mem", mem[0], 32'h556612BB);
        chk("sw4_mem", mem[1], 32'hDEADBEEF);
        do_req("lb1",  0, 3'b000, 32'd1, '0, 0, 32'h00000012, 2, 0);
        do_req("lh2b", 0, 3'b001, 32'd2, '0, 0, 32'h00005566, 2, 0);
        do_req("lb7",  0, 3'b000, 32'd7, '0, 0, 32'hFFFFFFDE, 2, 0);
        do_req("lhu6", 0, 3'b101, 32'd6, '0, 0, 32'h0000DEAD, 2, 0);
        do_req("swtop", 1, 3'b010, 32'(4 * MW - 4), 32'hA5A50F0F,
               0, '0, 2, 1);
        do_req("lwtop", 0, 3'b010, 32'(4 * MW - 4), '0,
               0, 32'hA5A50F0F, 2, 0);

        do_req("f_lw2",  0, 3'b010, 32'd2, '0, 1, '0, 2, 0);
        do_req("f_sh1",  1, 3'b001, 32'd1, 32'hFFFF, 1, '0, 2, 0);
        do_req("f_swoor", 1, 3'b010, 32'(4 * MW), 32'h1, 1, '0, 2, 0);
        do_req("f_lf3",  0, 3'b011, 32'd0, '0, 1, '0, 2, 0);
        do_req("f_sf4",  1, 3'b100, 32'd0, 32'h77, 1, '0, 2, 0);
        do_req("f_lboor", 0, 3'b000, 32'(4 * MW + 1), '0, 1, '0, 2, 0);
        chk("f_mem0", mem[0], 32'h556612BB);

        // start held during the done cycle is not taken until IDLE
        sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF, 2, 0});
        sb.push_back('{1'b0, 1'b1, 32'h556612BB, 2, 0});
        @(negedge clk);
        bus.start    = 1'b1;
        bus.is_store = 1'b0;
        bus.funct3   = 3'b010;
        bus.addr     = 32'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        g = sb.pop_front();
        chk("dd_done", bus.done, 1);
        chk("dd_rdata", bus.rdata, g.rdata);
        bus.start = 1'b1;
        bus.addr  = 32'd0;
        @(negedge clk);
        chk("dd_ignored", bus.busy, 0);
        chk("dd_nodone", bus.done, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("dd_accept", bus.busy, 1);
        @(posedge clk);
        @(negedge clk);
        g = sb.pop_front();
        chk("dd2_done", bus.done, 1);
        chk("dd2_rdata", bus.rdata, g.rdata);
        last_rd = g.rdata;
        @(negedge clk);

        // Reset while the write is pending must leave memory alone
        bus.start    = 1'b1;
        bus.is_store = 1'b1;
        bus.funct3   = 3'b010;
        bus.addr     = 32'd8;
        bus.wdata    = 32'hCAFEF00D;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("rw_we", bus.mem_we, 1);
        chk("rw_din", bus.mem_din, 32'hCAFEF00D);
        chk("rw_addr", bus.mem_addr, 32'd8);
        #2 rst = 1'b1;
        #1;
        chk("rw_we0", bus.mem_we, 0);
        chk("rw_busy", bus.busy, 0);
        chk("rw_done", bus.done, 0);
        chk("rw_fault", bus.fault, 0);
        chk("rw_rdata", bus.rdata, 0);
        chk("rw_maddr", bus.mem_addr, 0);
        chk("rw_mdin", bus.mem_din, 0);
        @(posedge clk);
        #1 chk("rw_mem2", mem[2], 32'h11111111);
        @(negedge clk);
        rst     = 1'b0;
        last_rd = '0;
        @(negedge clk);
        chk("rw_idle", bus.busy, 0);
        do_req("post_lw", 0, 3'b010, 32'd8, '0, 0, 32'h11111111, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
